// File: rtl/ad9637_spi_axil_regs.sv
// ad9637_spi_axil_regs: AXI4-Lite responder holding four 32-bit config words for the AD9637 SPI engine
module ad9637_spi_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_RESET_VALUE = '0
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
    output logic [3:0]                        reg_wr_pulse
);
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;
    logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs;
    logic aw_done, w_done, aw_done_n, w_done_n;
    logic [1:0] aw_hold;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_hold;
    logic [SW-1:0] s_hold;
    logic aw_hs, w_hs, ar_hs, commit, bvalid_n, rvalid_n;
    logic [1:0] widx;
    logic [C_S_AXI_DATA_WIDTH-1:0] wd;
    logic [SW-1:0] ws;
    logic unused;
    assign aw_hs = s00_axi_awvalid && s00_axi_awready;
    assign w_hs = s00_axi_wvalid && s00_axi_wready;
    assign ar_hs = s00_axi_arvalid && s00_axi_arready;
    // A channel that handshakes this cycle counts as already held, so AW+W together commit at once
    assign commit = (aw_done || aw_hs) && (w_done || w_hs);
    assign widx = aw_done ? aw_hold : s00_axi_awaddr[3:2];
    assign wd = w_done ? w_hold : s00_axi_wdata;
    assign ws = w_done ? s_hold : s00_axi_wstrb;
    assign aw_done_n = (aw_done || aw_hs) && !commit;
    assign w_done_n = (w_done || w_hs) && !commit;
    assign bvalid_n = commit || (s00_axi_bvalid && !s00_axi_bready);
    assign rvalid_n = ar_hs || (s00_axi_rvalid && !s00_axi_rready);
    assign reg_out = regs;
    assign s00_axi_bresp = 2'b00;
    assign s00_axi_rresp = 2'b00;
    assign unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            regs <= {4{C_RESET_VALUE}};
            aw_done <= 1'b0;
            w_done <= 1'b0;
            aw_hold <= '0;
            w_hold <= '0;
            s_hold <= '0;
            s00_axi_awready <= 1'b0;
            s00_axi_wready <= 1'b0;
            s00_axi_arready <= 1'b0;
            s00_axi_bvalid <= 1'b0;
            s00_axi_rvalid <= 1'b0;
            s00_axi_rdata <= '0;
            reg_wr_pulse <= '0;
        end else begin
            aw_done <= aw_done_n;
            w_done <= w_done_n;
            if (aw_hs) aw_hold <= s00_axi_awaddr[3:2];
            if (w_hs) begin
                w_hold <= s00_axi_wdata;
                s_hold <= s00_axi_wstrb;
            end
            s00_axi_awready <= !aw_done_n && !bvalid_n;
            s00_axi_wready <= !w_done_n && !bvalid_n;
            s00_axi_arready <= !rvalid_n;
            s00_axi_bvalid <= bvalid_n;
            s00_axi_rvalid <= rvalid_n;
            reg_wr_pulse <= commit ? 4'b0001 << widx : 4'b0000;
            // Sampled before this edge's commit lands, so a colliding read sees the old word
            if (ar_hs) s00_axi_rdata <= regs[s00_axi_araddr[3:2]];
            if (commit)
                for (int b = 0; b < SW; b++)
                    if (ws[b]) regs[widx][8*b +: 8] <= wd[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_ad9637_spi_axil_regs.sv
// tb_ad9637_spi_axil_regs: vector table, corner sequences and random traffic against a word-array model
module tb_ad9637_spi_axil_regs;
    logic clk = 1'b0;
    logic areset = 1'b1;
    logic [3:0] awaddr = '0, araddr = '0;
    logic [2:0] awprot = '0, arprot = '0;
    logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = '0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;
    logic [31:0] rdata;
    logic [127:0] reg_out;
    logic [3:0] reg_wr_pulse;
    int total = 0, bad = 0;
    logic [31:0] mdl [4];

    always #5 clk = ~clk;

    ad9637_spi_axil_regs dut (
        .s00_axi_aclk(clk), .s00_axi_areset(areset),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    task automatic check(input string n, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic logic [127:0] mdl_out();
        return {mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int ad, input int wd, input int bd);
        logic aw_ok, w_ok, haw, hw;
        int idx;
        idx = int'(a[3:2]);
        aw_ok = 0;
        w_ok = 0;
        awaddr = a;
        wdata = d;
        wstrb = s;
        for (int c = 0; c < 40 && !(aw_ok && w_ok); c++) begin
            awvalid = !aw_ok && c >= ad;
            wvalid = !w_ok && c >= wd;
            haw = awvalid && awready;
            hw = wvalid && wready;
            @(negedge clk);
            aw_ok |= haw;
            w_ok |= hw;
            if (haw) check("awready_drop", awready, 0);
            if (hw) check("wready_drop", wready, 0);
        end
        awvalid = 0;
        wvalid = 0;
        check("write_accept", aw_ok && w_ok, 1);
        for (int b = 0; b < 4; b++)
            if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
        check("bvalid_rise", bvalid, 1);
        check("bresp", bresp, 0);
        check("wr_pulse", reg_wr_pulse, 4'b0001 << idx);
        for (int c = 0; c < bd; c++) begin
            @(negedge clk);
            check("bvalid_hold", bvalid, 1);
            check("wr_ready_blocked", {awready, wready}, 0);
            check("wr_pulse_once", reg_wr_pulse, 0);
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        check("bvalid_clear", bvalid, 0);
        check("wr_pulse_off", reg_wr_pulse, 0);
        check("wr_ready_back", {awready, wready}, 2'b11);
        check("reg_out_model", reg_out, mdl_out());
    endtask

    task automatic do_read(input logic [3:0] a, input int rd, output logic [31:0] q);
        logic ok;
        ok = 0;
        araddr = a;
        arvalid = 1;
        for (int c = 0; c < 40 && !ok; c++) begin
            ok = arready;
            @(negedge clk);
        end
        arvalid = 0;
        check("ar_accept", ok, 1);
        check("rvalid_rise", rvalid, 1);
        check("rresp", rresp, 0);
        check("arready_drop", arready, 0);
        q = rdata;
        for (int c = 0; c < rd; c++) begin
            @(negedge clk);
            check("rvalid_hold", rvalid, 1);
            check("rdata_stable", rdata, q);
            check("arready_blocked", arready, 0);
        end
        rready = 1;
        @(negedge clk);
        rready = 0;
        check("rvalid_clear", rvalid, 0);
        check("arready_back", arready, 1);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [31:0] d;
        logic [3:0] s;
        int ad, wd, bd, rd;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] q;
        logic [3:0] a;
        tbl[0] = '{4'h0, 32'h1, 4'hF, 0, 0, 0, 0, 32'h1};
        tbl[1] = '{4'h4, 32'h2, 4'hF, 0, 0, 0, 0, 32'h2};
        tbl[2] = '{4'h8, 32'h3, 4'hF, 0, 0, 0, 0, 32'h3};
        tbl[3] = '{4'hC, 32'h4, 4'hF, 0, 0, 0, 0, 32'h4};
        tbl[4] = '{4'h4, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0, 32'hAABBCCDD};
        tbl[5] = '{4'h5, 32'h11223344, 4'b0101, 0, 0, 0, 0, 32'hAA22CC44};
        tbl[6] = '{4'h8, 32'h5A5A5A5A, 4'hF, 3, 0, 0, 0, 32'h5A5A5A5A};
        tbl[7] = '{4'h0, 32'hFFFFFFFF, 4'h0, 0, 1, 2, 0, 32'h1};
        tbl[8] = '{4'hC, 32'h4, 4'hF, 0, 0, 5, 4, 32'h4};
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_readies", {awready, wready, arready}, 0);
        check("rst_valids", {bvalid, rvalid}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_resp", {bresp, rresp}, 0);
        check("rst_pulse", reg_wr_pulse, 0);
        check("rst_regs", reg_out, 0);
        areset = 0;
        @(negedge clk);
        check("readies_after_rst", {awready, wready, arready}, 3'b111);

        for (int i = 0; i < 9; i++) begin
            do_write(tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].ad, tbl[i].wd, tbl[i].bd);
            do_read(tbl[i].a, tbl[i].rd, q);
            check($sformatf("vec%0d_read", i), q, tbl[i].exp);
            if (i == 3) check("reg_out_seq", reg_out, 128'h00000004_00000003_00000002_00000001);
        end
        check("reg_out_table", reg_out, 128'h00000004_5A5A5A5A_AA22CC44_00000001);

        check("idle_readies", {awready, wready, arready}, 3'b111);
        awaddr = 4'hC; wdata = 32'h99; wstrb = 4'hF; araddr = 4'hC;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        mdl[3] = 32'h99;
        check("collide_rvalid", rvalid, 1);
        check("collide_bvalid", bvalid, 1);
        check("collide_old_data", rdata, 32'h4);
        rready = 1;
        @(negedge clk);
        rready = 0; bready = 0;
        check("collide_done", {bvalid, rvalid}, 0);
        do_read(4'hC, 0, q);
        check("collide_new_data", q, 32'h99);

        for (int n = 0; n < 60; n++) begin
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else begin
                do_read(a, $urandom_range(0, 3), q);
                check("rand_read", q, mdl[a[3:2]]);
            end
        end

        @(negedge clk);
        awaddr = 4'h4; awvalid = 1;
        check("abort_awready", awready, 1);
        @(negedge clk);
        awvalid = 0; areset = 1;
        @(negedge clk);
        check("abort_readies", {awready, wready, arready}, 0);
        check("abort_bvalid", bvalid, 0);
        check("abort_regs", reg_out, 0);
        areset = 0;
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
        @(negedge clk);
        check("abort_readies_back", {awready, wready, arready}, 3'b111);
        check("abort_no_resp", bvalid, 0);
        do_write(4'h8, 32'hCAFEF00D, 4'hF, 1, 0, 0);
        do_read(4'h8, 0, q);
        check("post_abort_read", q, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ad9637_spi_axil_regs.md
Name: ad9637_spi_axil_regs

Overview:
AXI4-Lite responder (slave) for the AD9637 SPI configuration IP. It terminates the control bus from the PS or AXI VIP master and holds four 32-bit read/write registers. Register contents are exported to the SPI engine, with a one-cycle write pulse per register. It is the responder-side counterpart to the master that issues single-beat AXI4-Lite writes and reads at offsets 0x0, 0x4, 0x8 and 0xC.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register.
C_RESET_VALUE, 32'h0, reset value of all four registers.

Ports:
s00_axi_aclk  in  1  single clock; all logic on the rising edge
s00_axi_areset  in  1  synchronous, active-high reset
s00_axi_awaddr  in  4  write address
s00_axi_awprot  in  3  write protection; ignored
s00_axi_awvalid  in  1  write address valid
s00_axi_awready  out  1  write address ready
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  write byte strobes
s00_axi_wvalid  in  1  write data valid
s00_axi_wready  out  1  write data ready
s00_axi_bresp  out  2  write response; always 2'b00 (OKAY)
s00_axi_bvalid  out  1  write response valid
s00_axi_bready  in  1  write response ready
s00_axi_araddr  in  4  read address
s00_axi_arprot  in  3  read protection; ignored
s00_axi_arvalid  in  1  read address valid
s00_axi_arready  out  1  read address ready
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response; always 2'b00
s00_axi_rvalid  out  1  read data valid
s00_axi_rready  in  1  read data ready
reg_out  out  128  {reg3,reg2,reg1,reg0}, to the SPI engine
reg_wr_pulse  out  4  one-cycle strobe, bit n set when register n is written

Behaviour:
- Reset (synchronous, sampled on the clock edge):
  - all registers = C_RESET_VALUE
  - awready = wready = arready = 0
  - bvalid = rvalid = 0; rdata = 0; bresp = rresp = 0
  - reg_wr_pulse = 0
  - Reset asserted mid-transaction aborts it; no response is issued.
- Ready outputs are registered. Readies are 0 during reset and rise in the first cycle after reset deasserts.
- Write channel:
  - AW and W are accepted independently, in either order or together, and held in aw_hold / w_hold with flags aw_done / w_done.
  - awready = !aw_done && !bvalid; wready = !w_done && !bvalid.
  - A channel is accepted in the cycle where its valid && ready are both 1. Its ready drops the following cycle.
  - Commit happens in the first cycle where both flags are set, or both channels handshake in the same cycle:
    - register[addr[3:2]] bytes are updated where wstrb = 1; bytes with wstrb = 0 keep their value
    - reg_wr_pulse[idx] = 1 for exactly one cycle, even when wstrb = 0
    - bvalid = 1 in the cycle after commit
    - both flags clear
  - bvalid holds until bready. The next AW/W can be accepted in the cycle after the B handshake.
  - Exactly one write is outstanding at a time.
  - addr[1:0] is ignored; misaligned addresses are truncated to the word.
  - Best-case latency: AW+W handshake at cycle t, bvalid at t+1, ready again at t+2 if bready is held 1.
- Read channel:
  - arready = !rvalid && !ar_pending.
  - On the AR handshake at cycle t: rdata = register[araddr[3:2]] as sampled at t, and rvalid = 1 at t+1.
  - rdata and rvalid hold stable until rready. arready is 1 again the cycle after the R handshake.
- Simultaneous read and write of the same register in the same cycle: the read returns the pre-write value; the write commits normally.
- Read and write paths are independent; neither stalls the other.
- reg_out reflects register state combinationally from the flops; updates are visible the cycle after commit.
- Protocol invariants: valid is never dropped before its handshake; payload stays stable while valid && !ready.

Test Plan:
1. Sequential writes 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC (wstrb = 0xF), then read back the same addresses -> reads return 0x1, 0x2, 0x3, 0x4; every resp = 00; reg_out = 128'h00000004_00000003_00000002_00000001.
2. Byte strobes: write 0xAABBCCDD to 0x4, then write 0x11223344 with wstrb = 4'b0101 -> reading 0x4 returns 0xAA22CC44; reg_wr_pulse[1] fires once per write.
3. Channel skew: W presented 3 cycles before AW (addr 0x8, data 0x5A5A5A5A) -> wready drops after the W handshake; bvalid rises the cycle after AW is accepted; reg2 = 0x5A5A5A5A.
4. Backpressure: hold bready = 0 for 5 cycles and rready = 0 for 4 cycles -> bvalid/rvalid and rdata stay stable; awready = wready = 0 and arready = 0 until the respective handshakes complete.
5. Same-cycle AR and write-commit on 0xC (old value 0x4, new value 0x99) -> rdata = 0x4; a subsequent read returns 0x99.
6. Reset asserted one cycle after the AW handshake, with W still pending -> bvalid stays 0, all registers = 0, all readies = 0 during reset, and readies return to 1 one cycle after release.
